// File: rtl/instr_seq_pkg.sv
// Shared state encodings and default timing parameters for the nibble CPU sequencer.
// Types and constants only; no logic, no latency, no flow control.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5,
    ST_STEP   = 3'd6
  } seq_state_t;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int TMO_W_DEF       = 8;

endpackage

// File: rtl/instr_seq_timeout.sv
// seq_timeout: loadable saturating wait counter; expired is combinational, same cycle as en.
// No handshake: clr beats ld beats en; the count saturates at all-ones and never wraps.
module seq_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

  // Fires in the cycle whose increment would reach limit, so a wait lasts exactly limit cycles.
  assign expired = en && (({1'b0, count} + (W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/instr_seq.sv
// instr_seq: fetch/decode/mem/exec sequencer; 2-cycle minimum instruction, memory waits on mem_rdy.
// Stalls in FETCH/MEM until mem_rdy or timeout; optional single-step via INSTR_SEQ_SINGLE_STEP_EN.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TMO_W       = TMO_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       halt_req,
  input  logic       dec_mem,
  input  logic       dec_we,
  input  logic       dec_arith,
  input  logic       mem_rdy,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       alu_en,
  output logic       busy,
  output logic       bus_err,
  output logic [2:0] state
);

  seq_state_t state_q;
  seq_state_t state_d;
  seq_state_t boundary;
  logic       bus_err_q;
  logic       tmo_en;
  logic       tmo_clr;
  logic       tmo_exp;

  assign tmo_en  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_rdy;
  assign tmo_clr = mem_rdy || (state_d != state_q);

  seq_timeout #(
    .W (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .ld      (1'b0),
    .ld_val  ('0),
    .en      (tmo_en),
    .limit   (TMO_W'(MEM_TIMEOUT)),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tmo_exp) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    // Where a completed instruction goes next; halt only ever takes effect here.
    if (halt_req) begin
      boundary = ST_HALT;
    end else if (!run) begin
      boundary = ST_IDLE;
    end else begin
`ifdef INSTR_SEQ_SINGLE_STEP_EN
      boundary = ST_STEP;
`else
      boundary = ST_FETCH;
`endif
    end

    state_d = ST_IDLE;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    alu_en  = 1'b0;
    busy    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        state_d = (run && !halt_req) ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_rdy;
        pc_inc  = mem_rdy;
        if (mem_rdy)      state_d = ST_DECODE;
        else if (tmo_exp) state_d = ST_HALT;
        else              state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_mem)        state_d = ST_MEM;
        else if (dec_arith) state_d = ST_EXEC;
        else                state_d = boundary;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_we;
        if (mem_rdy)      state_d = boundary;
        else if (tmo_exp) state_d = ST_HALT;
        else              state_d = ST_MEM;
      end
      ST_EXEC: begin
        alu_en  = 1'b1;
        state_d = boundary;
      end
      ST_HALT: begin
        busy    = 1'b0;
        state_d = (halt_req || bus_err_q) ? ST_HALT : ST_IDLE;
      end
`ifdef INSTR_SEQ_SINGLE_STEP_EN
      ST_STEP: begin
        busy = 1'b0;
        if (halt_req)  state_d = ST_HALT;
        else if (step) state_d = ST_FETCH;
        else           state_d = ST_STEP;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Instruction-cycle sequencer for the nibble CPU.
- Drives the fetch → decode → memory/execute cycle around the combinational decoder.
- Owns the memory request handshake, instruction-register load strobe, PC increment strobe, and the single-cycle ALU enable.
- Sits between the decoder outputs (mem-access, write-enable, arithmetic flags) and the PC/IR/memory/ALU datapath.

Parameters:
- MEM_TIMEOUT, 15: cycles to wait for mem_rdy before flagging a bus error. Legal range 1..255.
- TMO_W, 8: width of the timeout counter. Must hold MEM_TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; sequencer leaves IDLE/HALT while high.
- halt_req  input  1  level; stop at the next instruction boundary.
- dec_mem  input  1  decoded instruction is a memory access (load/store).
- dec_we  input  1  decoded memory access is a store; ignored unless dec_mem.
- dec_arith  input  1  decoded instruction uses the ALU.
- mem_rdy  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_we  output  1  request is a write; valid only with mem_req.
- ir_load  output  1  one-cycle strobe; IR captures the fetched byte.
- pc_inc  output  1  one-cycle strobe; PC advances by one.
- alu_en  output  1  one-cycle ALU capture enable.
- busy  output  1  high in any state other than IDLE/HALT.
- bus_err  output  1  sticky; set on memory timeout.
- state  output  3  current state encoding, for debug/trace.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM=3, EXEC=4, HALT=5. Codes 6 and 7 are illegal and return to IDLE on the next cycle.
- Reset (rst=1 at posedge) has priority over all other inputs and applies mid-operation too:
  - state=IDLE; timeout counter=0; bus_err=0.
  - All strobes, mem_req and mem_we are 0 in the cycle after reset.
- IDLE:
  - run=1 and halt_req=0 → FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req=1, mem_we=0.
  - mem_rdy=1 → ir_load=1 and pc_inc=1 in that same cycle; next state DECODE.
  - mem_rdy=0 → counter increments.
  - Counter reaching MEM_TIMEOUT with mem_rdy still 0 → bus_err=1, next state HALT.
- DECODE: one cycle; decoder outputs are sampled here.
  - dec_mem=1 → MEM.
  - else dec_arith=1 → EXEC.
  - else → instruction boundary (see below).
  - dec_mem and dec_arith both high: dec_mem wins.
- MEM:
  - mem_req=1, mem_we=dec_we.
  - dec_* are held stable by the IR, so re-reading them is safe.
  - Same rdy/timeout rules as FETCH, but no ir_load and no pc_inc.
  - Completion → instruction boundary.
- EXEC:
  - alu_en=1 for exactly one cycle.
  - Then → instruction boundary.
- Instruction boundary, evaluated in the completing cycle:
  - halt_req=1 → HALT.
  - else run=0 → IDLE.
  - else → FETCH.
- Fetch latency: the next FETCH follows the completing cycle immediately. Minimum instruction time is 2 cycles (FETCH with immediate rdy + DECODE).
- HALT:
  - Stay while halt_req=1 or bus_err=1.
  - Otherwise → IDLE.
  - bus_err clears only on rst.
- Timeout counter:
  - Clears on every state entry and whenever mem_rdy=1.
  - Saturates; never wraps.
- mem_rdy outside FETCH/MEM is ignored.
- halt_req is never honoured mid-instruction.
- Outputs are Moore-decoded from state, except ir_load/pc_inc, which are gated by mem_rdy (Mealy).

Optional Feature:
- Macro: INSTR_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit, pulse).
  - Adds state STEP=6.
  - Every instruction boundary goes to STEP instead of FETCH.
  - STEP → FETCH on step=1.
  - halt_req in STEP → HALT.
  - busy=0 in STEP.
- When undefined: no step port; code 6 is illegal; behaviour exactly as above.

Decomposition:
- Shared package/header (alongside opcode.vh): state encodings, MEM_TIMEOUT default.
- Natural sub-module: seq_timeout (loadable saturating counter with clear, enable and expired flag), reused by future bus masters.

Test Plan:
- Reset then run=1, dec_*=0, mem_rdy tied 1:
  - state sequence 0,1,2,1,2…
  - pc_inc pulses every 2 cycles; ir_load coincident with pc_inc.
- Store instruction (dec_mem=1, dec_we=1), mem_rdy delayed 3 cycles in MEM:
  - mem_req=1, mem_we=1 for 4 cycles; no pc_inc in MEM; then FETCH.
- Arithmetic instruction (dec_arith=1):
  - alu_en high exactly 1 cycle, in state 4; next state 1.
- mem_rdy held 0 in FETCH, MEM_TIMEOUT=4:
  - bus_err=1 after 4 cycles; state=5; stays 5 until rst; rst clears to state 0, bus_err 0.
- halt_req asserted during MEM wait:
  - instruction completes; state→5 at the boundary; release halt_req → 0 → 1 (run=1).
- With INSTR_SEQ_SINGLE_STEP_EN:
  - after one instruction, state=6, busy=0.
  - one step pulse → exactly one more fetch (one pc_inc), then back to 6.
